count_ctrl: RTL and testbench
=============================

COUNT_CTRL -- requirements
Module: count_ctrl

Interface
REQ-001 SHALL have parameter NUM_CNT_BITS, default 4, width of the counter rollover value.
REQ-002 SHALL have parameter NUM_IDX_BITS, default 4, width of bit-count and bit-index fields.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock, all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  one-cycle request to begin a sequence, sampled only in IDLE.
REQ-007 bit_period  input  NUM_CNT_BITS  clocks per bit.
REQ-008 num_bits  input  NUM_IDX_BITS  bits per sequence.
REQ-009 cnt_rollover_flag  input  1  rollover flag returned by the attached counter.
REQ-010 cnt_clear  output  1  clear to counter.
REQ-011 cnt_enable  output  1  count enable to counter.
REQ-012 cnt_rollover_val  output  NUM_CNT_BITS  rollover value to counter.
REQ-013 busy  output  1  high in any non-IDLE state.
REQ-014 bit_strobe  output  1  one-cycle pulse per completed bit period.
REQ-015 bit_index  output  NUM_IDX_BITS  completed bits so far in the current sequence.
REQ-016 done  output  1  one-cycle end-of-sequence pulse.

Function
REQ-017 SHALL implement FSM states IDLE, CLEAR, COUNT, DONE.
REQ-018 IDLE: start=1 -> CLEAR; latch bit_period and num_bits into internal registers on the same edge.
REQ-019 CLEAR lasts one cycle: cnt_clear=1, cnt_enable=0, bit_index reset to 0.
REQ-020 CLEAR -> COUNT if latched num_bits>0; CLEAR -> DONE if num_bits==0.
REQ-021 COUNT: cnt_enable=1 continuously, cnt_clear=0.
REQ-022 COUNT: bit_strobe = cnt_rollover_flag (combinational, same cycle); outside COUNT, bit_strobe=0.
REQ-023 COUNT: on each flag, bit_index increments; the flag completing bit num_bits-1 moves state to DONE.
REQ-024 DONE lasts one cycle: done=1, cnt_enable=0, then -> IDLE.
REQ-025 cnt_rollover_val SHALL be the latched period, clamped to 2 when the latched value is 0 or 1.
REQ-026 bit_index holds its final value in DONE and IDLE until the next CLEAR.
REQ-027 start while busy SHALL be ignored, with no effect on the latched values.
REQ-028 Changes to bit_period or num_bits while busy SHALL be ignored.
REQ-029 When paired with the team's 4-bit flex counter, period R, N bits, start sampled at edge 0:
  - bit_strobe at cycles 2+R*k, k=1..N
  - done at cycle 3+R*N
  - busy high cycles 1 through 3+R*N

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE; busy, done, bit_strobe, cnt_clear, cnt_enable, bit_index all 0.
REQ-031 Reset SHALL also force cnt_rollover_val to 2.
REQ-032 rst during any state SHALL abort immediately with no done pulse; rst has priority over start.

Configuration
REQ-033 Macro COUNT_CTRL_ABORT_EN, when defined, SHALL add input abort (1 bit).
REQ-034 With the macro, abort=1 in CLEAR or COUNT SHALL move to DONE next cycle with done=1 and bit_index frozen; abort has priority over a coincident final flag.
REQ-035 With the macro, abort in IDLE or DONE SHALL have no effect.
REQ-036 Without the macro, the abort port SHALL be absent and behaviour is exactly REQ-017..REQ-032.

Verification
REQ-037 R=4, N=3, start at cycle 0 -> cnt_clear at cycle 1, strobes at 6/10/14, done at 15, bit_index=3.
REQ-038 num_bits=0, start -> CLEAR at cycle 1, done at cycle 2, no cnt_enable, no strobe.
REQ-039 bit_period=1, N=2 -> cnt_rollover_val=2, strobes at 4/6, done at 7.
REQ-040 Second start at cycle 5 during R=4/N=3 run, plus bit_period changed to 7 -> timing unchanged from REQ-037.
REQ-041 rst at cycle 8 of R=4/N=3 run -> cycle 9 IDLE, all outputs 0, no done; new start then runs normally.
REQ-042 With COUNT_CTRL_ABORT_EN, abort at cycle 8 (R=4, N=3) -> done at cycle 9, bit_index=1, cnt_enable 0 from cycle 9.

Source files
------------

// File: rtl/count_ctrl.sv
// count_ctrl
// ----------
// Sequencer that drives an external flex counter to time a burst of
// equally spaced bit periods. On a start request it latches the period and
// bit count, clears the counter for one cycle, then enables it and treats
// every rollover flag as the end of one bit. After the last bit it raises a
// one-cycle done pulse and returns to idle.
//
// Optional feature: define COUNT_CTRL_ABORT_EN to add the 'abort' input,
// which ends a running sequence early (through DONE) with bit_index frozen.
//
// Ports
//   clk               in   system clock, rising edge
//   rst               in   synchronous active-high reset
//   start             in   begin a sequence (only honoured in IDLE)
//   bit_period        in   clocks per bit (latched at start)
//   num_bits          in   bits per sequence (latched at start)
//   cnt_rollover_flag in   rollover flag from the attached counter
//   abort             in   (COUNT_CTRL_ABORT_EN only) early termination
//   cnt_clear         out  counter clear, high in CLEAR
//   cnt_enable        out  counter enable, high in COUNT
//   cnt_rollover_val  out  latched period, clamped to a minimum of 2
//   busy              out  high in any non-IDLE state
//   bit_strobe        out  counter flag gated by COUNT
//   bit_index         out  bits completed in the current sequence
//   done              out  one-cycle end-of-sequence pulse
module count_ctrl #(
  parameter int NUM_CNT_BITS = 4,
  parameter int NUM_IDX_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NUM_CNT_BITS-1:0] bit_period,
  input  logic [NUM_IDX_BITS-1:0] num_bits,
  input  logic                    cnt_rollover_flag,
`ifdef COUNT_CTRL_ABORT_EN
  input  logic                    abort,
`endif
  output logic                    cnt_clear,
  output logic                    cnt_enable,
  output logic [NUM_CNT_BITS-1:0] cnt_rollover_val,
  output logic                    busy,
  output logic                    bit_strobe,
  output logic [NUM_IDX_BITS-1:0] bit_index,
  output logic                    done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_CNT_BITS-1:0] period_q, period_d;
  logic [NUM_IDX_BITS-1:0] nbits_q, nbits_d;
  logic [NUM_IDX_BITS-1:0] bit_index_q, bit_index_d;
  logic [NUM_IDX_BITS-1:0] idx_inc_s;
  logic                    abort_s;

  // A counter with rollover value 0 or 1 would never produce a usable
  // flag cadence, so the shortest honoured bit period is 2 clocks.
  function automatic logic [NUM_CNT_BITS-1:0] clamp_period(
    input logic [NUM_CNT_BITS-1:0] p
  );
    if (p < NUM_CNT_BITS'(2)) begin
      clamp_period = NUM_CNT_BITS'(2);
    end else begin
      clamp_period = p;
    end
  endfunction

`ifdef COUNT_CTRL_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  assign idx_inc_s = bit_index_q + NUM_IDX_BITS'(1);

  // Next-state and latched-parameter logic.
  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    nbits_d     = nbits_q;
    bit_index_d = bit_index_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = CLEAR;
          period_d    = clamp_period(bit_period);
          nbits_d     = num_bits;
          bit_index_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        if (abort_s) begin
          state_d = DONE;
        end else if (nbits_q == '0) begin
          state_d = DONE;
        end else begin
          state_d = COUNT;
        end
      end
      COUNT: begin
        // Abort wins over a coincident flag: index stays frozen.
        if (abort_s) begin
          state_d = DONE;
        end else if (cnt_rollover_flag) begin
          bit_index_d = idx_inc_s;
          if (idx_inc_s == nbits_q) begin
            state_d = DONE;
          end else begin
            state_d = COUNT;
          end
        end else begin
          state_d = COUNT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;
    busy       = 1'b0;
    bit_strobe = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
      end
      CLEAR: begin
        busy      = 1'b1;
        cnt_clear = 1'b1;
      end
      COUNT: begin
        busy       = 1'b1;
        cnt_enable = 1'b1;
        bit_strobe = cnt_rollover_flag;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign cnt_rollover_val = period_q;
  assign bit_index        = bit_index_q;

  // State and latched-parameter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      period_q    <= NUM_CNT_BITS'(2);
      nbits_q     <= '0;
      bit_index_q <= '0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      nbits_q     <= nbits_d;
      bit_index_q <= bit_index_d;
    end
  end

endmodule

// File: tb/tb_count_ctrl.sv
// Directed bench for count_ctrl, paired with a 4-bit flex counter model.
module tb_count_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] bit_period = 4'd0;
  logic [3:0] num_bits = 4'd0;
  logic       cnt_rollover_flag;
  logic       abort = 1'b0;
  logic       cnt_clear, cnt_enable, busy, bit_strobe, done;
  logic [3:0] cnt_rollover_val, bit_index;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  count_ctrl #(.NUM_CNT_BITS(4), .NUM_IDX_BITS(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .bit_period       (bit_period),
    .num_bits         (num_bits),
    .cnt_rollover_flag(cnt_rollover_flag),
`ifdef COUNT_CTRL_ABORT_EN
    .abort            (abort),
`endif
    .cnt_clear        (cnt_clear),
    .cnt_enable       (cnt_enable),
    .cnt_rollover_val (cnt_rollover_val),
    .busy             (busy),
    .bit_strobe       (bit_strobe),
    .bit_index        (bit_index),
    .done             (done)
  );

  // Flex counter: counts 1..R, flag registered high while count equals R.
  logic [3:0] fc_cnt_q;
  logic [3:0] fc_next;
  logic       fc_flag_q;
  assign cnt_rollover_flag = fc_flag_q;
  always_comb fc_next = (fc_cnt_q == cnt_rollover_val) ? 4'd1 : fc_cnt_q + 4'd1;
  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      fc_cnt_q  <= 4'd0;
      fc_flag_q <= 1'b0;
    end else if (cnt_enable) begin
      fc_cnt_q  <= fc_next;
      fc_flag_q <= (fc_next == cnt_rollover_val);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input int idx, input int rv);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " strobe"}, 32'(bit_strobe), 32'd0);
    chk({tag, " clear"}, 32'(cnt_clear), 32'd0);
    chk({tag, " enable"}, 32'(cnt_enable), 32'd0);
    chk({tag, " idx"}, 32'(bit_index), 32'(idx));
    chk({tag, " rval"}, 32'(cnt_rollover_val), 32'(rv));
  endtask

  // Start at edge 0, then check every cycle through the done cycle and one
  // idle cycle after it. 'disturb' fires a second start and new inputs at
  // cycle 5, which must not alter anything.
  task automatic run_seq(input string name, input int per, input int n, input bit disturb);
    int r;
    int last;
    int e_idx;
    string t;
    r    = (per < 2) ? 2 : per;
    last = (n == 0) ? 2 : 3 + r * n;
    bit_period = 4'(per);
    num_bits   = 4'(n);
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= last; c++) begin
      t     = $sformatf("%s c%0d", name, c);
      e_idx = (c < 3 || n == 0) ? 0 : (c - 3) / r;
      if (e_idx > n) e_idx = n;
      chk({t, " busy"}, 32'(busy), 32'd1);
      chk({t, " clear"}, 32'(cnt_clear), 32'(c == 1));
      chk({t, " enable"}, 32'(cnt_enable), 32'(n != 0 && c >= 2 && c < last));
      chk({t, " strobe"}, 32'(bit_strobe),
          32'(n != 0 && c > 2 && c < last && ((c - 2) % r) == 0));
      chk({t, " done"}, 32'(done), 32'(c == last));
      chk({t, " idx"}, 32'(bit_index), 32'(e_idx));
      chk({t, " rval"}, 32'(cnt_rollover_val), 32'(r));
      if (disturb && c == 5) begin
        start      = 1'b1;
        bit_period = 4'd7;
        num_bits   = 4'd9;
      end else if (disturb && c == 6) begin
        start = 1'b0;
      end
      tick();
    end
    chk_idle({name, " after"}, n, r);
  endtask

  initial begin
    // Reset state
    tick();
    chk_idle("reset", 0, 2);
    // Reset has priority over start
    start = 1'b1;
    bit_period = 4'd5;
    num_bits = 4'd2;
    tick();
    chk_idle("rst_vs_start", 0, 2);
    start = 1'b0;
    rst   = 1'b0;
    tick();
    chk_idle("idle", 0, 2);

    // R=4, N=3 nominal: strobes 6/10/14, done 15, final index 3
    run_seq("r4n3", 4, 3, 1'b0);
    // num_bits = 0: done at cycle 2, never enabled
    run_seq("n0", 5, 0, 1'b0);
    // Period 1 clamps to 2: strobes 4/6, done 7
    run_seq("p1n2", 1, 2, 1'b0);
    // Period 0 also clamps to 2
    run_seq("p0n1", 0, 1, 1'b0);
    // Second start and input changes while busy are ignored
    run_seq("busy_ign", 4, 3, 1'b1);
    // Longest configuration edge: N=15 with period 2
    run_seq("n15", 2, 15, 1'b0);

    // Reset at cycle 8 of a R=4/N=3 run
    bit_period = 4'd4;
    num_bits   = 4'd3;
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 8; c++) tick();
    chk("mid c8 idx", 32'(bit_index), 32'd1);
    chk("mid c8 enable", 32'(cnt_enable), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("mid_rst c9", 0, 2);
    tick();
    chk_idle("mid_rst c10", 0, 2);
    tick();
    chk_idle("mid_rst c11", 0, 2);
    run_seq("post_rst", 4, 3, 1'b0);

`ifdef COUNT_CTRL_ABORT_EN
    // Abort in IDLE has no effect
    abort = 1'b1;
    tick();
    chk_idle("abort_idle", 3, 4);
    abort = 1'b0;
    // Abort at cycle 8 of R=4/N=3: done at 9 with index 1
    bit_period = 4'd4;
    num_bits   = 4'd3;
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 8; c++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort c9 done", 32'(done), 32'd1);
    chk("abort c9 idx", 32'(bit_index), 32'd1);
    chk("abort c9 enable", 32'(cnt_enable), 32'd0);
    chk("abort c9 busy", 32'(busy), 32'd1);
    tick();
    chk_idle("abort c10", 1, 4);
    // Abort coincident with the final flag (cycle 14) freezes index at 2
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 14; c++) tick();
    chk("abort_fin c14 strobe", 32'(bit_strobe), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_fin c15 done", 32'(done), 32'd1);
    chk("abort_fin c15 idx", 32'(bit_index), 32'd2);
    tick();
    chk_idle("abort_fin c16", 2, 4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
